// File: rtl/placar_controle.sv
// Basketball scoreboard controller: press detection, per-team score registers,
// range-checked add/subtract and horn/LED alarm. Optional filter: PLACAR_DEBOUNCE_EN.
module placar_controle #(
    parameter int MAX_SCORE       = 99,
    parameter int BUZZ_CYCLES     = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_A,
    input  logic       i_B,
    input  logic       i_C,
    input  logic       i_ChaveNegativaPositiva,
    input  logic       i_MudarTime,
    output logic [6:0] o_PlacarA,
    output logic [6:0] o_PlacarB,
    output logic       o_TimeAtivo,
    output logic       o_Busina,
    output logic       o_LedErro,
    output logic       o_Ocupado
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ESPERA} state_t;

    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    state_t         r_state, w_next;
    logic [3:0]     w_raw, w_flt, r_prev, w_press;
    logic [1:0]     w_pts, r_pts;
    logic           r_op, r_team, r_time, r_err;
    logic [6:0]     r_placar_a, r_placar_b, w_score;
    logic [7:0]     w_res;
    logic           w_legal;
    logic [BW-1:0]  r_buzz;

    // Bit order {MudarTime, C, B, A} is shared by the filter and edge registers
    assign w_raw = {i_MudarTime, i_C, i_B, i_A};

`ifdef PLACAR_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [DW-1:0] r_cnt;
        always_ff @(posedge i_Clock) begin
            if (i_Reset || !w_raw[g])
                r_cnt <= '0;
            else if (r_cnt != DW'(DEBOUNCE_CYCLES))
                r_cnt <= r_cnt + 1'b1;
        end
        assign w_flt[g] = (r_cnt == DW'(DEBOUNCE_CYCLES));
    end
`else
    assign w_flt = w_raw;
`endif

    assign w_press = w_flt & ~r_prev;

    // Highest-valued button wins; lower presses in the same cycle are dropped
    always_comb begin
        w_pts = 2'd0;
        if (w_press[2])      w_pts = 2'd3;
        else if (w_press[1]) w_pts = 2'd2;
        else if (w_press[0]) w_pts = 2'd1;
    end

    assign w_score = r_team ? r_placar_b : r_placar_a;
    assign w_res   = r_op ? ({1'b0, w_score} - {6'd0, r_pts})
                          : ({1'b0, w_score} + {6'd0, r_pts});
    assign w_legal = r_op ? ({1'b0, w_score} >= {6'd0, r_pts})
                          : (w_res <= 8'(MAX_SCORE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pts != 2'd0) w_next = S_CALC;
            S_CALC:   w_next = S_ESPERA;
            S_ESPERA: if (w_flt[2:0] == 3'b000) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_prev     <= '0;
            r_pts      <= '0;
            r_op       <= 1'b0;
            r_team     <= 1'b0;
            r_time     <= 1'b0;
            r_err      <= 1'b0;
            r_placar_a <= '0;
            r_placar_b <= '0;
            r_buzz     <= '0;
        end else begin
            r_prev <= w_flt;
            if (r_state == S_IDLE) begin
                // Team is captured before the toggle lands on the same edge
                if (w_pts != 2'd0) begin
                    r_pts  <= w_pts;
                    r_op   <= i_ChaveNegativaPositiva;
                    r_team <= r_time;
                end
                if (w_press[3]) r_time <= ~r_time;
            end
            if (r_state == S_CALC) begin
                if (w_legal) begin
                    if (r_team) r_placar_b <= w_res[6:0];
                    else        r_placar_a <= w_res[6:0];
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_CALC && !w_legal)
                r_buzz <= BW'(BUZZ_CYCLES);
            else if (r_buzz != '0)
                r_buzz <= r_buzz - 1'b1;
        end
    end

    assign o_PlacarA   = r_placar_a;
    assign o_PlacarB   = r_placar_b;
    assign o_TimeAtivo = r_time;
    assign o_Busina    = (r_buzz != '0);
    assign o_LedErro   = r_err;
    assign o_Ocupado   = (r_state != S_IDLE);

endmodule

// File: tb/tb_placar_controle.sv
// Directed bench for placar_controle with a scoreboard of expected score/team/LED state.
module tb_placar_controle;

    logic       clk = 1'b0, rst = 1'b1;
    logic       a = 0, b = 0, c = 0, sub = 0, m = 0;
    logic [6:0] pa, pb;
    logic       t, busina, led, ocupado;

`ifdef PLACAR_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
        logic       t;
        logic       e;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0, checks = 0;
    logic [6:0] m_a = 0, m_b = 0;
    logic       m_t = 0, m_e = 0;

    placar_controle dut (
        .i_Clock(clk), .i_Reset(rst), .i_A(a), .i_B(b), .i_C(c),
        .i_ChaveNegativaPositiva(sub), .i_MudarTime(m),
        .o_PlacarA(pa), .o_PlacarB(pb), .o_TimeAtivo(t),
        .o_Busina(busina), .o_LedErro(led), .o_Ocupado(ocupado)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60 && ocupado; k++) @(negedge clk);
        chk(tag, ocupado, 0);
    endtask

    // One point press (optionally with a team-change press), held for `hold` cycles
    task automatic press(input logic [2:0] abc, input logic mt, input logic op,
                         input int hold, input bit mid_m);
        exp_t e;
        int   pts, sc, cnt;
        bit   team, rej;
        @(negedge clk);
        a = abc[0]; b = abc[1]; c = abc[2]; m = mt; sub = op;
        pts  = abc[2] ? 3 : abc[1] ? 2 : 1;
        team = m_t;
        if (mt) m_t = ~m_t;
        sc  = team ? int'(m_b) : int'(m_a);
        rej = 0;
        if (op) begin
            if (sc >= pts) sc -= pts; else rej = 1;
        end else begin
            if (sc + pts <= 99) sc += pts; else rej = 1;
        end
        if (!rej) begin
            if (team) m_b = 7'(sc); else m_a = 7'(sc);
            m_e = 0;
        end else m_e = 1;
        sb.push_back('{m_a, m_b, m_t, m_e});
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        m = 0;
        sub = ~op;
        chk("busy_calc", ocupado, 1);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("placar_a", pa, e.a);
        chk("placar_b", pb, e.b);
        chk("time", t, e.t);
        chk("led", led, e.e);
        if (rej && hold <= 2) begin
            cnt = 0;
            while (busina && cnt < 30) begin cnt++; @(negedge clk); end
            chk("buzz_len", cnt, 8);
        end
        for (int i = 2; i < hold; i++) begin
            @(negedge clk);
            if (mid_m && i == 3) m = 1;
            if (mid_m && i == 3 + LAT + 2) m = 0;
        end
        @(negedge clk);
        a = 0; b = 0; c = 0; m = 0;
        wait_idle("idle");
        chk("stable_a", pa, m_a);
        chk("stable_b", pb, m_b);
        chk("stable_t", t, m_t);
    endtask

    task automatic toggle();
        @(negedge clk);
        m = 1;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        m = 0;
        m_t = ~m_t;
        chk("toggle", t, m_t);
        chk("toggle_idle", ocupado, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_a", pa, 0); chk("rst_b", pb, 0); chk("rst_t", t, 0);
        chk("rst_buz", busina, 0); chk("rst_led", led, 0); chk("rst_ocup", ocupado, 0);

        press(3'b010, 0, 0, 1, 0);            // A: 0 -> 2
        press(3'b001, 0, 1, 1, 0);            // A: 2 -> 1
        press(3'b100, 0, 1, 1, 0);            // 1 - 3 rejected, horn 8 cycles
        press(3'b001, 0, 1, 1, 0);            // A: 1 -> 0, LED cleared

        toggle();                             // team B
        for (int i = 0; i < 32; i++) press(3'b100, 0, 0, 1, 0);
        press(3'b010, 0, 0, 1, 0);            // B = 98
        press(3'b010, 0, 0, 1, 0);            // 100 rejected
        press(3'b001, 0, 0, 1, 0);            // B = 99
        press(3'b001, 0, 0, 1, 0);            // 100 rejected

        toggle();                             // team A
        press(3'b101, 0, 0, 20, 0);           // A+C together -> +3, held
        press(3'b001, 1, 0, 1, 0);            // point + toggle together
        press(3'b001, 0, 0, 12, 1);           // toggle during ESPERA ignored

        if (m_t) toggle();
        press(3'b001, 0, 0, 1, 0);            // A = 5
        chk("pre_rst_a", pa, 5);

        // Reset while the next press is in CALC: no write happens
        @(negedge clk);
        a = 1; sub = 0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        chk("rst_in_calc", ocupado, 1);
        rst = 1; a = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_a = 0; m_b = 0; m_t = 0; m_e = 0;
        chk("rst2_a", pa, 0); chk("rst2_b", pb, 0); chk("rst2_buz", busina, 0);
        chk("rst2_ocup", ocupado, 0); chk("rst2_t", t, 0);

        press(3'b010, 0, 0, 1, 0);            // A = 2 after reset

`ifdef PLACAR_DEBOUNCE_EN
        @(negedge clk);
        a = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 0;
        repeat (10) @(negedge clk);
        chk("glitch_a", pa, m_a);
        chk("glitch_idle", ocupado, 0);
        @(negedge clk);
        a = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = 0;
        m_a = m_a + 7'd1;
        repeat (4) @(negedge clk);
        chk("deb_press_a", pa, m_a);
        wait_idle("deb_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
